// File: rtl/cc_io_strobe_latch.sv
// I/O window write-strobe decoder with an addressable output latch bank and a
// frame-counting watchdog that raises a timed CPU reset request.
module cc_io_strobe_latch #(
    parameter logic [15:0] IO_BASE          = 16'h9C00,
    parameter int          SPAN_LOG2        = 7,
    parameter int          STROBE_N         = 8,
    parameter int          LATCH_N          = 16,
    parameter int          LATCH_DBIT       = 3,
    parameter int          LATCH_STROBE     = 6,
    parameter int          LATCH_CLR_STROBE = 0,
    parameter int          WDOG_STROBE      = 4,
    parameter int          WDOG_LIMIT       = 8,
    parameter int          WDOG_PULSE       = 16
) (
    input  logic                CLK10,
    input  logic                RESET,
    input  logic                CPU_EN,
    input  logic [15:0]         BA,
    input  logic [7:0]          BD,
    input  logic                WRITEn,
    input  logic                VBL_EN,
    input  logic                WDOG_DIS,
    output logic [STROBE_N-1:0] STROBE,
    output logic [LATCH_N-1:0]  LATCH,
    output logic                WDOG_RST
);

    // state | meaning
    // RUN   | counting frames since the last kick
    // FIRE  | reset pulse in progress, pulse_cnt counts down to terminal 0
    typedef enum logic {RUN, FIRE} wdog_state_t;

    localparam int SLOT_W  = $clog2(STROBE_N);
    localparam int LATCH_W = $clog2(LATCH_N);
    localparam int TOP     = SPAN_LOG2 + SLOT_W;

    logic              hit;
    logic [SLOT_W-1:0] slot;
    logic              kick;
    logic              unused_bits;

    wdog_state_t       state;
    logic [7:0]        wdog_cnt;
    logic [7:0]        pulse_cnt;
    logic [STROBE_N-1:0] strobe_q;
    logic [LATCH_N-1:0]  latch_q;
    logic              wdog_rst_q;

    assign hit  = CPU_EN && !WRITEn && ((BA >> TOP) == (IO_BASE >> TOP));
    assign slot = BA[TOP-1:SPAN_LOG2];
    assign kick = hit && (slot == SLOT_W'(WDOG_STROBE));

    // Only one data bit and the low address bits reach the latch bank.
    assign unused_bits = ^{BD, BA};

    always_ff @(posedge CLK10) begin
        if (RESET) begin
            strobe_q <= '0;
            latch_q  <= '0;
        end else begin
            strobe_q <= hit ? (STROBE_N'(1) << slot) : '0;
            if (hit && slot == SLOT_W'(LATCH_CLR_STROBE))
                latch_q <= '0;
            else if (hit && slot == SLOT_W'(LATCH_STROBE))
                latch_q[BA[LATCH_W-1:0]] <= BD[LATCH_DBIT];
        end
    end

    always_ff @(posedge CLK10) begin
        if (RESET) begin
            state      <= RUN;
            wdog_cnt   <= 8'd0;
            pulse_cnt  <= 8'd0;
            wdog_rst_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (kick || WDOG_DIS) begin
                        wdog_cnt <= 8'd0;
                    end else if (VBL_EN) begin
                        if (wdog_cnt + 8'd1 == 8'(WDOG_LIMIT)) begin
                            wdog_cnt   <= 8'd0;
                            pulse_cnt  <= 8'(WDOG_PULSE - 1);
                            wdog_rst_q <= 1'b1;
                            state      <= FIRE;
                        end else begin
                            wdog_cnt <= wdog_cnt + 8'd1;
                        end
                    end
                end
                FIRE: begin
                    wdog_cnt <= 8'd0;
                    if (pulse_cnt == 8'd0) begin
                        wdog_rst_q <= 1'b0;
                        state      <= RUN;
                    end else begin
                        pulse_cnt <= pulse_cnt - 8'd1;
                    end
                end
                default: begin
                    wdog_rst_q <= 1'b0;
                    state      <= RUN;
                end
            endcase
        end
    end

    assign STROBE   = strobe_q;
    assign LATCH    = latch_q;
    assign WDOG_RST = wdog_rst_q;

endmodule

// File: tb/tb_cc_io_strobe_latch.sv
// Bench for cc_io_strobe_latch: directed scenarios plus randomized traffic,
// every cycle compared against a window/slot/frame-count model of the block.
module tb_cc_io_strobe_latch;

    localparam int BASE   = 32'h9C00;
    localparam int SPAN   = 128;
    localparam int NSLOT  = 8;
    localparam int LIMIT  = 8;
    localparam int PULSE  = 16;

    logic        clk = 1'b0;
    logic        RESET, CPU_EN, WRITEn, VBL_EN, WDOG_DIS;
    logic [15:0] BA;
    logic [7:0]  BD;
    logic [7:0]  STROBE;
    logic [15:0] LATCH;
    logic        WDOG_RST;

    int tests  = 0;
    int errors = 0;
    logic rst_seen;

    logic [7:0]  m_strobe;
    logic [15:0] m_latch;
    int          m_cnt, m_pulse;

    cc_io_strobe_latch dut (
        .CLK10(clk), .RESET(RESET), .CPU_EN(CPU_EN), .BA(BA), .BD(BD),
        .WRITEn(WRITEn), .VBL_EN(VBL_EN), .WDOG_DIS(WDOG_DIS),
        .STROBE(STROBE), .LATCH(LATCH), .WDOG_RST(WDOG_RST)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: slot from address arithmetic, watchdog as frame count plus
    // remaining pulse cycles.
    always @(posedge clk) begin
        int  slot;
        bit  busy;
        if (RESET) begin
            m_strobe = '0; m_latch = '0; m_cnt = 0; m_pulse = 0;
        end else begin
            slot = -1;
            if (CPU_EN && !WRITEn && int'(BA) >= BASE && int'(BA) < BASE + NSLOT*SPAN)
                slot = (int'(BA) - BASE) / SPAN;
            m_strobe = (slot >= 0) ? 8'(1 << slot) : 8'h00;
            if (slot == 6) m_latch[int'(BA) % 16] = BD[3];
            if (slot == 0) m_latch = '0;
            busy = (m_pulse > 0);
            if (busy) m_pulse--;
            if (slot == 4 || WDOG_DIS || busy) m_cnt = 0;
            else if (VBL_EN) begin
                m_cnt++;
                if (m_cnt == LIMIT) begin
                    m_cnt = 0;
                    m_pulse = PULSE;
                end
            end
        end
        #1;
        chk("strobe", STROBE, m_strobe);
        chk("latch", LATCH, m_latch);
        chk("wdog_rst", WDOG_RST, m_pulse > 0);
    end

    task automatic drive(input logic ce, input logic [15:0] a, input logic [7:0] d,
                         input logic wn, input logic v);
        CPU_EN = ce; BA = a; BD = d; WRITEn = wn; VBL_EN = v;
        @(negedge clk);
        rst_seen |= WDOG_RST;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic vbl_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
            idle(1);
        end
    endtask

    task automatic count_high(input int n, inout int hi);
        for (int i = 0; i < n; i++) begin
            idle(1);
            hi += int'(WDOG_RST);
        end
    endtask

    initial begin
        int hi;
        RESET = 1'b1; WDOG_DIS = 1'b0; rst_seen = 1'b0;
        CPU_EN = 1'b0; BA = '0; BD = '0; WRITEn = 1'b1; VBL_EN = 1'b0;
        @(negedge clk);
        idle(2);
        RESET = 1'b0;
        chk("reset_strobe", STROBE, 8'h00);
        chk("reset_latch", LATCH, 16'h0000);
        chk("reset_wdog", WDOG_RST, 1'b0);

        drive(1'b1, 16'h9E80, 8'h00, 1'b0, 1'b0);
        chk("strobe_9e80", STROBE, 8'h20);
        idle(1);
        chk("strobe_one_cycle", STROBE, 8'h00);
        drive(1'b1, 16'h9E80, 8'h00, 1'b1, 1'b0);
        chk("strobe_read", STROBE, 8'h00);

        drive(1'b1, 16'h9F03, 8'h08, 1'b0, 1'b0);
        chk("latch_bit3", LATCH, 16'h0008);
        drive(1'b1, 16'h9F0F, 8'h08, 1'b0, 1'b0);
        chk("latch_bit15", LATCH, 16'h8008);
        chk("model_latch", m_latch, 16'h8008);
        drive(1'b1, 16'h9C00, 8'h00, 1'b0, 1'b0);
        chk("clr_strobe", STROBE, 8'h01);
        chk("latch_clear", LATCH, 16'h0000);

        drive(1'b1, 16'h9C80, 8'h00, 1'b0, 1'b0);
        chk("b2b_first", STROBE, 8'h02);
        drive(1'b1, 16'h9D00, 8'h00, 1'b0, 1'b0);
        chk("b2b_second", STROBE, 8'h04);

        drive(1'b1, 16'h9F05, 8'h08, 1'b0, 1'b0);
        drive(1'b1, 16'h8E80, 8'h00, 1'b0, 1'b0);
        chk("oow_8e80", STROBE, 8'h00);
        drive(1'b1, 16'hA000, 8'h00, 1'b0, 1'b0);
        chk("oow_a000", STROBE, 8'h00);
        drive(1'b1, 16'h9BFF, 8'h00, 1'b0, 1'b0);
        chk("oow_latch", LATCH, 16'h0020);

        rst_seen = 1'b0;
        vbl_pulses(7);
        chk("wdog_quiet_7", rst_seen, 1'b0);
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
        chk("wdog_fire", WDOG_RST, 1'b1);
        chk("model_pulse", m_pulse, PULSE);
        hi = 1;
        count_high(20, hi);
        chk("wdog_len", hi, PULSE);

        rst_seen = 1'b0;
        vbl_pulses(7);
        drive(1'b1, 16'h9E00, 8'h00, 1'b0, 1'b0);
        vbl_pulses(7);
        chk("wdog_kicked", rst_seen, 1'b0);

        drive(1'b1, 16'h9E00, 8'h00, 1'b0, 1'b1);
        idle(1);
        vbl_pulses(7);
        chk("kick_beats_vbl", rst_seen, 1'b0);
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
        chk("fire_after_kick", WDOG_RST, 1'b1);
        idle(3);
        drive(1'b1, 16'h9E00, 8'h00, 1'b0, 1'b1);
        hi = 5;
        count_high(20, hi);
        chk("kick_no_shorten", hi, PULSE);

        rst_seen = 1'b0;
        WDOG_DIS = 1'b1;
        vbl_pulses(20);
        WDOG_DIS = 1'b0;
        chk("wdog_dis", rst_seen, 1'b0);

        drive(1'b1, 16'h9F01, 8'h08, 1'b0, 1'b0);
        vbl_pulses(7);
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
        idle(4);
        chk("pulse_cycle5", WDOG_RST, 1'b1);
        RESET = 1'b1;
        drive(1'b1, 16'h9E80, 8'h00, 1'b0, 1'b0);
        RESET = 1'b0;
        chk("rst_mid_wdog", WDOG_RST, 1'b0);
        chk("rst_mid_latch", LATCH, 16'h0000);
        chk("rst_mid_strobe", STROBE, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            CPU_EN   = 1'($urandom_range(0, 1));
            BA       = ($urandom_range(0, 9) < 7) ? 16'(BASE + $urandom_range(0, 1023)) : 16'($urandom);
            BD       = 8'($urandom);
            WRITEn   = ($urandom_range(0, 3) == 0);
            VBL_EN   = ($urandom_range(0, 7) == 0);
            WDOG_DIS = ($urandom_range(0, 39) == 0);
            RESET    = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        for (int i = 0; i < 1500; i++) begin
            CPU_EN   = ($urandom_range(0, 9) == 0);
            BA       = 16'(BASE + $urandom_range(0, 1023));
            BD       = 8'($urandom);
            WRITEn   = 1'($urandom_range(0, 1));
            VBL_EN   = 1'($urandom_range(0, 1));
            WDOG_DIS = ($urandom_range(0, 99) == 0);
            RESET    = 1'b0;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
